// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: turns symbolic ADDI/BNE/LUI commands into RV32I words and
// streams them to consecutive instruction-memory word addresses through a
// one-entry output register. Illegal commands are consumed and flagged on err.
module rv_inst_encoder #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [31:0]   cmd_imm,
  output logic          im_we,
  input  logic          im_ready,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          err,
  output logic          full,
  output logic [AW:0]   wr_count
);

  localparam logic [1:0] OP_ADDI = 2'd0;
  localparam logic [1:0] OP_BNE  = 2'd1;
  localparam logic [1:0] OP_LUI  = 2'd2;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  logic          s1_valid_q, s1_valid_d;
  logic [31:0]   s1_data_q,  s1_data_d;
  logic [AW-1:0] ptr_q,      ptr_d;
  logic          full_q,     full_d;
  logic [AW:0]   cnt_q,      cnt_d;
  logic          err_q,      err_d;

  logic        accept;
  logic        drain;
  logic        legal;
  logic [31:0] enc_word;

  // Handshake: blocked during start, once full, or while the stage is stuck.
  always_comb begin
    cmd_ready = reset_n & ~start & ~full_q & (~s1_valid_q | im_ready);
    accept    = cmd_valid & cmd_ready;
    drain     = s1_valid_q & im_ready;
  end

  // Range check and RV32I encoding of the presented command.
  always_comb begin
    legal    = 1'b0;
    enc_word = 32'd0;
    case (cmd_op)
      OP_ADDI: begin
        legal    = ($signed(cmd_imm) >= -32'sd2048) && ($signed(cmd_imm) <= 32'sd2047);
        enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OPC_OPIMM};
      end
      OP_BNE: begin
        legal    = ($signed(cmd_imm) >= -32'sd4096) && ($signed(cmd_imm) <= 32'sd4094)
                   && !cmd_imm[0];
        enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b001,
                    cmd_imm[4:1], cmd_imm[11], OPC_BRANCH};
      end
      OP_LUI: begin
        legal    = 1'b1;
        enc_word = {cmd_imm[19:0], cmd_rd, OPC_LUI};
      end
      default: begin
        legal    = 1'b0;
        enc_word = 32'd0;
      end
    endcase
  end

  // Next-state for stage register, write pointer, full flag, count and err.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    ptr_d      = ptr_q;
    full_d     = full_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    if (start) begin
      // A pending word is discarded even if the memory would take it now.
      s1_valid_d = 1'b0;
      ptr_d      = start_addr;
      full_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      if (drain) begin
        s1_valid_d = 1'b0;
        ptr_d      = ptr_q + AW'(1);
        if (&ptr_q) full_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + (AW+1)'(1);
      end
      if (accept) begin
        if (legal) begin
          s1_valid_d = 1'b1;
          s1_data_d  = enc_word;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'd0;
      ptr_q      <= '0;
      full_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      ptr_q      <= ptr_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    im_we    = s1_valid_q;
    im_addr  = ptr_q;
    im_wdata = s1_data_q;
    err      = err_q;
    full     = full_q;
    wr_count = cnt_q;
  end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
Instruction writer for the core's fetch path. Accepts symbolic instruction commands (ADDI, BNE, LUI), range-checks them and encodes each into a 32-bit RV32I word. Legal words go through a one-entry output register and are written to sequential word addresses of instruction memory. Used by test/boot logic to load programs that the core's decoder then executes.

Parameters:
AW, 10, instruction-memory word-address width; depth is 2^AW words.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  load write pointer, flush pipeline, clear full/count
start_addr  in  AW  first word address after start
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=ADDI, 1=BNE, 2=LUI, 3=reserved
cmd_rd  in  5  destination register (ADDI, LUI)
cmd_rs1  in  5  source 1 (ADDI, BNE)
cmd_rs2  in  5  source 2 (BNE)
cmd_imm  in  32  ADDI: signed value; BNE: signed byte offset; LUI: imm[19:0] is the upper-20 field, imm[31:20] ignored
im_we  out  1  write request
im_ready  in  1  memory accepts write when im_we&im_ready
im_addr  out  AW  word address
im_wdata  out  32  encoded instruction
err  out  1  one-cycle pulse: rejected command
full  out  1  last address written; sticky until start or reset
wr_count  out  AW+1  words written since start or reset

Behaviour:
- Reset (reset_n=0 at clk edge) overrides everything. im_we=0, im_addr=0, im_wdata=0, err=0, full=0, wr_count=0. Stage register is invalid. Reset mid-write drops the pending word.
- cmd_ready = reset_n & !start & !full & (!s1_valid | im_ready). This is combinational from state and im_ready.
- Encoding: funct3 ADDI=000, BNE=001. Opcodes: OPIMM 0010011, BRANCH 1100011, LUI 0110111.
  - ADDI = {imm[11:0], rs1, 000, rd, 0010011}.
  - BNE = {imm[12], imm[10:5], rs2, rs1, 001, imm[4:1], imm[11], 1100011}.
  - LUI = {imm[19:0], rd, 0110111}.
- Legality:
  - ADDI needs cmd_imm in -2048..2047.
  - BNE needs cmd_imm in -4096..4094 and cmd_imm[0]=0.
  - LUI is always legal.
  - op=3 is illegal.
- An illegal command is still accepted (handshake completes). No word is produced, and err pulses high the next cycle. Legal commands never assert err.
- A legal accept at cycle N loads the stage register and drives im_we=1 from cycle N+1 onward.
- im_we, im_addr and im_wdata hold stable until im_ready. When im_ready=1 and no new accept occurs, im_we drops the following cycle.
- Back-to-back throughput is 1 word/cycle when im_ready stays high: accept and drain happen in the same cycle.
- Write pointer and count:
  - The pointer advances by 1 on each completed write; wr_count increments on each completed write.
  - A completed write to address 2^AW-1 sets full. The pointer wraps to 0 but no further command is accepted until start.
  - wr_count saturates at 2^AW.
- start (priority over all except reset), in one cycle:
  - pointer <= start_addr; full, wr_count, err <= 0; stage register invalidated.
  - A word pending at im_we is discarded even if im_ready is high.
  - No command is accepted in that cycle.
- im_addr always equals the current write pointer.

Test Plan:
- Reset, start with start_addr=0. Send ADDI rd=1,rs1=0,imm=5 -> next cycle im_we=1, im_addr=0, im_wdata=0x00500093. Then ADDI rd=1,rs1=0,imm=-1 -> addr 1, data 0xFFF00093; wr_count=2.
- LUI rd=2,imm=0x12345 then BNE rs1=1,rs2=2,imm=-8, back to back with im_ready=1 -> data 0x12345137 then 0xFE209CE3 on consecutive cycles; cmd_ready stays 1.
- ADDI imm=2048; BNE imm=7; BNE imm=4096; op=3 -> each is accepted, err pulses 1 cycle, im_we stays 0, wr_count unchanged.
- Pending word with im_ready=0 for 3 cycles -> im_we/im_addr/im_wdata stable and cmd_ready=0. im_ready=1 -> write completes and the next queued command is accepted the same cycle.
- AW=4, start_addr=14, write 2 words -> addresses 14, 15; full=1, im_addr=0, cmd_ready=0. Third command is held. start with start_addr=3 -> full=0, wr_count=0, next write goes to address 3.
- Assert reset_n=0 while im_we=1, im_ready=0 -> next cycle all outputs are at reset values. After release and start, the first write goes to start_addr.
